// File: rtl/rx_cmd_decoder_pkg.sv
// Shared UART system definitions: command codes, decoder state encoding and
// the helper that says which states are guarded by the inter-byte timeout.
package rx_cmd_decoder_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

  // TX_SEND waits on the transmitter indefinitely, so it is not timed.
  function automatic logic is_timed(input state_e s);
    return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT};
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Saturating idle-cycle counter; flags expiry once it has counted
// TIMEOUT_CYC-1 enabled cycles since the last clear.
module rx_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Saturation keeps expiry asserted if a dropped byte blocks the abort.
  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Decodes UART command frames (write: AA addr data, read: BB addr) into
// register-file strobes and returns read data to the transmitter.
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  RdEn,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  Cmd_Err,
  output logic                  Frame_Err,
  output logic                  Drop
);

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wrdata_nxt, w_txdata_nxt;
  logic                  w_txvld_nxt, w_wren_nxt, w_rden_nxt;
  logic                  w_cmderr_nxt, w_frmerr_nxt, w_drop_nxt;
  logic                  w_accept, w_expired, w_timeout, w_cnt_clr;

  // A byte or read data arriving on the expiry cycle takes precedence.
  assign w_timeout = w_expired && !RX_D_VLD && !(RdData_Valid && (r_state == ST_RD_WAIT));
  assign w_cnt_clr = w_accept || ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE));

  rx_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_en      (is_timed(r_state)),
    .i_clr     (w_cnt_clr),
    .o_expired (w_expired)
  );

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = Address;
    w_wrdata_nxt = WrData;
    w_txdata_nxt = TX_P_DATA;
    w_txvld_nxt  = TX_D_VLD;
    w_wren_nxt   = 1'b0;
    w_rden_nxt   = 1'b0;
    w_cmderr_nxt = 1'b0;
    w_frmerr_nxt = 1'b0;
    w_drop_nxt   = 1'b0;
    w_accept     = 1'b0;

    unique case (r_state)
      ST_IDLE: if (RX_D_VLD) begin
        w_accept = 1'b1;
        if (RX_P_DATA == DATA_WIDTH'(CMD_WR))      w_state_nxt = ST_WR_ADDR;
        else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) w_state_nxt = ST_RD_ADDR;
        else                                       w_cmderr_nxt = 1'b1;
      end
      ST_WR_ADDR, ST_RD_ADDR: if (RX_D_VLD) begin
        w_accept    = 1'b1;
        w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
        w_rden_nxt  = (r_state == ST_RD_ADDR);
        w_state_nxt = (r_state == ST_RD_ADDR) ? ST_RD_WAIT : ST_WR_DATA;
      end else if (w_timeout) begin
        w_frmerr_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        w_accept     = 1'b1;
        w_wrdata_nxt = RX_P_DATA;
        w_wren_nxt   = 1'b1;
        w_state_nxt  = ST_IDLE;
      end else if (w_timeout) begin
        w_frmerr_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_RD_WAIT: begin
        w_drop_nxt = RX_D_VLD;
        if (RdData_Valid) begin
          w_txdata_nxt = RdData;
          w_txvld_nxt  = 1'b1;
          w_state_nxt  = ST_TX_SEND;
        end else if (w_timeout) begin
          w_frmerr_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_TX_SEND: begin
        w_drop_nxt = RX_D_VLD;
        if (TX_D_VLD && !TX_Busy) begin
          w_txvld_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Cmd_Err   <= 1'b0;
      Frame_Err <= 1'b0;
      Drop      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      Address   <= w_addr_nxt;
      WrData    <= w_wrdata_nxt;
      TX_P_DATA <= w_txdata_nxt;
      TX_D_VLD  <= w_txvld_nxt;
      WrEn      <= w_wren_nxt;
      RdEn      <= w_rden_nxt;
      Cmd_Err   <= w_cmderr_nxt;
      Frame_Err <= w_frmerr_nxt;
      Drop      <= w_drop_nxt;
    end
  end

endmodule
